// File: rtl/cep_stream_reader_pkg.sv
// Shared constants, FSM encoding and buffer word layout for the cepstrum
// coefficient read path.
package cep_stream_reader_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int ADDR_WIDTH_14 = 14;
    localparam int CEP_NUM_WIDTH = 7;
    localparam int FRAME_WIDTH   = 7;
    localparam int BUF_DEPTH     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last_coef;
        logic                  last_frame;
    } cep_word_t;

    // Coefficient memory is laid out frame-major: {frame_idx, coef_idx}.
    function automatic logic [ADDR_WIDTH_14-1:0] cep_addr(
        input logic [FRAME_WIDTH-1:0]   frame_idx,
        input logic [CEP_NUM_WIDTH-1:0] coef_idx
    );
        return {frame_idx, coef_idx};
    endfunction

endpackage

// File: rtl/cep_stream_reader_if.sv
// Coefficient output stream. A word transfers on a rising clock edge where
// out_valid && out_ready; while out_valid && !out_ready the master holds
// out_data and both tags stable, and out_valid never drops before transfer.
interface cep_stream_reader_if;
    import cep_stream_reader_pkg::*;

    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last_coef;
    logic                  out_last_frame;

    modport master (
        output out_data, out_valid, out_last_coef, out_last_frame,
        input  out_ready
    );

    modport slave (
        input  out_data, out_valid, out_last_coef, out_last_frame,
        output out_ready
    );

endinterface

// File: rtl/cep_out_buf.sv
// Two-entry FIFO of tagged coefficient words; the head entry drives the
// output stream directly from registers.
module cep_out_buf
    import cep_stream_reader_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  cep_word_t push_word,
    input  logic      pop,
    output cep_word_t head_word,
    output logic [1:0] count
);

    cep_word_t  mem_q [BUF_DEPTH];
    cep_word_t  mem_d [BUF_DEPTH];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_word;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        // Push and pop together leave occupancy unchanged.
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_word = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/cep_stream_reader.sv
// Reads cepstrum coefficients frame by frame from the coefficient memory and
// streams them, tagged with end-of-frame / end-of-pass flags, to downstream.
module cep_stream_reader
    import cep_stream_reader_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rd_start,
    input  logic [CEP_NUM_WIDTH-1:0] cep_num,
    input  logic [FRAME_WIDTH-1:0]   frame_total,
    output logic [ADDR_WIDTH_14-1:0] cep_mem_read_addr,
    output logic                     cep_mem_read_en,
    input  logic [DATA_WIDTH-1:0]    cep_mem_data_in,
    cep_stream_reader_if.master      out_if,
    output logic                     rd_busy,
    output logic                     rd_done,
    output rd_state_e                dbg_state
);

    rd_state_e                state_q, state_d;
    logic [CEP_NUM_WIDTH-1:0] cep_num_q, cep_num_d;
    logic [FRAME_WIDTH-1:0]   frame_total_q, frame_total_d;
    logic [CEP_NUM_WIDTH-1:0] coef_idx_q, coef_idx_d;
    logic [FRAME_WIDTH-1:0]   frame_idx_q, frame_idx_d;
    logic                     inflight_q, inflight_d;
    logic                     tag_coef_q, tag_coef_d;
    logic                     tag_frame_q, tag_frame_d;
    logic [ADDR_WIDTH_14-1:0] addr_q, addr_d;

    cep_word_t  buf_head;
    cep_word_t  buf_push_word;
    logic [1:0] buf_count;
    logic       buf_valid;
    logic       buf_pop;
    logic [2:0] pending;
    logic       issue;
    logic       last_coef;
    logic       last_frame;

    assign buf_valid = (buf_count != 2'd0);
    assign buf_pop   = buf_valid && out_if.out_ready;
    // A word leaving this cycle frees its slot for a read issued this cycle.
    assign pending   = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, buf_pop};

    always_comb begin
        state_d       = state_q;
        cep_num_d     = cep_num_q;
        frame_total_d = frame_total_q;
        coef_idx_d    = coef_idx_q;
        frame_idx_d   = frame_idx_q;
        tag_coef_d    = tag_coef_q;
        tag_frame_d   = tag_frame_q;
        issue         = 1'b0;
        last_coef     = (coef_idx_q == cep_num_q - 7'd1);
        last_frame    = (frame_idx_q == frame_total_q - 7'd1);
        case (state_q)
            ST_IDLE: begin
                if (rd_start) begin
                    cep_num_d     = cep_num;
                    frame_total_d = frame_total;
                    coef_idx_d    = '0;
                    frame_idx_d   = '0;
                    state_d = (cep_num == '0 || frame_total == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (pending < 3'd2) begin
                    issue       = 1'b1;
                    tag_coef_d  = last_coef;
                    tag_frame_d = last_frame;
                    if (last_coef) begin
                        coef_idx_d  = '0;
                        frame_idx_d = frame_idx_q + 7'd1;
                        if (last_frame) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        coef_idx_d = coef_idx_q + 7'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (!buf_valid && !inflight_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        inflight_d        = issue;
        cep_mem_read_en   = issue;
        cep_mem_read_addr = issue ? cep_addr(frame_idx_q, coef_idx_q) : addr_q;
        addr_d            = cep_mem_read_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cep_num_q     <= '0;
            frame_total_q <= '0;
            coef_idx_q    <= '0;
            frame_idx_q   <= '0;
            inflight_q    <= 1'b0;
            tag_coef_q    <= 1'b0;
            tag_frame_q   <= 1'b0;
            addr_q        <= '0;
        end else begin
            state_q       <= state_d;
            cep_num_q     <= cep_num_d;
            frame_total_q <= frame_total_d;
            coef_idx_q    <= coef_idx_d;
            frame_idx_q   <= frame_idx_d;
            inflight_q    <= inflight_d;
            tag_coef_q    <= tag_coef_d;
            tag_frame_q   <= tag_frame_d;
            addr_q        <= addr_d;
        end
    end

    // Read data arrives one cycle after issue, joined with tags held since issue.
    assign buf_push_word = '{data: cep_mem_data_in, last_coef: tag_coef_q, last_frame: tag_frame_q};

    cep_out_buf u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_word (buf_push_word),
        .pop       (buf_pop),
        .head_word (buf_head),
        .count     (buf_count)
    );

    assign out_if.out_data       = buf_head.data;
    assign out_if.out_last_coef  = buf_head.last_coef;
    assign out_if.out_last_frame = buf_head.last_frame;
    assign out_if.out_valid      = buf_valid;

    assign rd_busy   = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign rd_done   = (state_q == ST_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cep_stream_reader.sv
// Randomised bench for cep_stream_reader: memory model, frame-major reference
// word/address queues, and a cycle monitor for ordering, stalls and occupancy.
`timescale 1ns/1ps
module tb_cep_stream_reader;
  import cep_stream_reader_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rd_start = 1'b0;
  logic [6:0] cep_num = '0;
  logic [6:0] frame_total = '0;
  logic [13:0] cep_mem_read_addr;
  logic cep_mem_read_en;
  logic [31:0] cep_mem_data_in = '0;
  logic rd_busy, rd_done;
  rd_state_e dbg_state;

  cep_stream_reader_if out_if ();

  cep_stream_reader dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rd_start          (rd_start),
    .cep_num           (cep_num),
    .frame_total       (frame_total),
    .cep_mem_read_addr (cep_mem_read_addr),
    .cep_mem_read_en   (cep_mem_read_en),
    .cep_mem_data_in   (cep_mem_data_in),
    .out_if            (out_if.master),
    .rd_busy           (rd_busy),
    .rd_done           (rd_done),
    .dbg_state         (dbg_state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // memory model: synchronous one-cycle read
  logic [31:0] mem [16384];
  always @(posedge clk) begin
    if (cep_mem_read_en) cep_mem_data_in <= mem[cep_mem_read_addr];
  end

  // reference expectations: {data, last_coef, last_frame} and read addresses
  logic [33:0] exp_q[$];
  logic [13:0] exp_addr_q[$];

  task automatic build_expected(input int c, input int f);
    for (int fi = 0; fi < f; fi++) begin
      for (int ci = 0; ci < c; ci++) begin
        logic [13:0] a;
        a = 14'(fi * 128 + ci);
        exp_addr_q.push_back(a);
        exp_q.push_back({mem[a], ci == c - 1, fi == f - 1});
      end
    end
  endtask

  // ready driver: 0 = always, 1 = pattern 1,0,0,1, 2 = random, 3 = never
  int ready_mode = 0;
  logic ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  initial begin
    int ph;
    ph = 0;
    out_if.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_if.out_ready = 1'b1;
        1: begin out_if.out_ready = ready_pat[ph]; ph = (ph + 1) % 4; end
        2: out_if.out_ready = 1'($urandom_range(0, 1));
        default: out_if.out_ready = 1'b0;
      endcase
    end
  end

  // monitor: transfers, reads, stall stability, modelled occupancy
  int occ_m = 0;
  logic rd_prev = 1'b0;
  logic stall_prev = 1'b0;
  logic [34:0] stall_word = '0;
  logic mon_pop;
  int reads = 0;
  int pops = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      occ_m = 0;
      rd_prev = 1'b0;
      stall_prev = 1'b0;
    end else begin
      mon_pop = out_if.out_valid && out_if.out_ready;
      chk("valid_vs_occ", out_if.out_valid, occ_m != 0);
      if (stall_prev)
        chk("stall_hold", {out_if.out_valid, out_if.out_last_coef, out_if.out_last_frame, out_if.out_data}, stall_word);
      if (mon_pop) begin
        pops++;
        if (exp_q.size() > 0) begin
          logic [33:0] e;
          e = exp_q.pop_front();
          chk("out_data", out_if.out_data, e[33:2]);
          chk("last_coef", out_if.out_last_coef, e[1]);
          chk("last_frame", out_if.out_last_frame, e[0]);
        end else begin
          chk("extra_word", 1, 0);
        end
      end
      if (cep_mem_read_en) begin
        reads++;
        if (exp_addr_q.size() > 0) chk("read_addr", cep_mem_read_addr, exp_addr_q.pop_front());
        else chk("extra_read", 1, 0);
        chk("issue_room", (occ_m - int'(mon_pop) + int'(rd_prev)) < 2, 1);
      end
      stall_prev = out_if.out_valid && !out_if.out_ready;
      stall_word = {out_if.out_valid, out_if.out_last_coef, out_if.out_last_frame, out_if.out_data};
      occ_m = occ_m + int'(rd_prev) - int'(mon_pop);
      if (occ_m > 2) chk("occ_max", occ_m, 2);
      rd_prev = cep_mem_read_en;
    end
  end

  task automatic run_pass(input int c, input int f, input int mode, input int restart_cyc);
    int cyc, limit, reads0, pops0;
    ready_mode = mode;
    build_expected(c, f);
    reads0 = reads;
    pops0 = pops;
    limit = c * f * 4 + 50;
    @(negedge clk);
    rd_start = 1'b1;
    cep_num = 7'(c);
    frame_total = 7'(f);
    @(posedge clk);
    @(negedge clk);
    rd_start = 1'b0;
    chk("busy_start", rd_busy, (c * f) != 0);
    cyc = 0;
    while (!rd_done && cyc < limit) begin
      rd_start = (cyc == restart_cyc);
      if (cyc == restart_cyc) begin
        cep_num = 7'(c + 2);
        frame_total = 7'(f + 1);
      end
      @(negedge clk);
      cyc++;
    end
    rd_start = 1'b0;
    chk("done_timeout", cyc < limit, 1);
    if (mode == 0) chk("done_latency", cyc, (c * f == 0) ? 0 : c * f + 3);
    chk("busy_at_done", rd_busy, 0);
    chk("reads_total", reads - reads0, c * f);
    chk("words_total", pops - pops0, c * f);
    chk("exp_left", exp_q.size(), 0);
    chk("addr_left", exp_addr_q.size(), 0);
    @(negedge clk);
    chk("done_pulse_end", rd_done, 0);
    chk("idle_after", dbg_state, ST_IDLE);
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, out_if.out_valid, 0);
    chk({tag, "_data"}, out_if.out_data, 0);
    chk({tag, "_tags"}, {out_if.out_last_coef, out_if.out_last_frame}, 0);
    chk({tag, "_rden"}, cep_mem_read_en, 0);
    chk({tag, "_addr"}, cep_mem_read_addr, 0);
    chk({tag, "_busy_done"}, {rd_busy, rd_done}, 0);
    chk({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_pass(3, 2, 0, -1);
    run_pass(3, 2, 1, -1);
    run_pass(0, 5, 0, -1);
    run_pass(4, 0, 0, -1);
    run_pass(5, 4, 0, 6);
    run_pass(3, 3, 1, 2);
    for (int k = 0; k < 3; k++)
      run_pass($urandom_range(1, 9), $urandom_range(1, 6), 2, -1);

    // reset in the middle of a stalled pass
    ready_mode = 3;
    build_expected(5, 3);
    @(negedge clk);
    rd_start = 1'b1;
    cep_num = 7'd5;
    frame_total = 7'd3;
    @(negedge clk);
    rd_start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pending_before_reset", out_if.out_valid, 1);
    chk("fetch_before_reset", dbg_state, ST_FETCH);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    exp_q.delete();
    exp_addr_q.delete();
    repeat (2) @(negedge clk);
    check_all_zero("held_reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("no_restart", rd_busy, 0);
    run_pass(2, 1, 0, -1);

    run_pass(127, 127, 0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
